dot_product_sequencer: RTL and testbench

Controller that drives one `dotProduct` datapath through a full DIM×DIM matrix multiply C = A·B. It walks every (row i of A, column j of B) pair, issues operand-memory reads, tracks each issued pair through the datapath latency and writes each scalar result to the C result memory. It sits between the operand/result memories and the `dotProduct` instance in the matrix-multiply engine. It issues one pair per cycle with no bubbles.

---
 rtl/dot_product_sequencer.sv | 144 ++++++++++++++
 tb/tb_dot_product_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: walks every (row of A, column of B) pair for a
// DIM x DIM matrix multiply, issues operand reads one pair per cycle,
// tracks each pair through the dotProduct latency and writes results to C.
module dot_product_sequencer #(
    parameter int DIM          = 8,
    parameter int A_DATA_WIDTH = 32,
    parameter int B_DATA_WIDTH = 32,
    parameter int DP_LATENCY   = 0,
    localparam int IDX_W       = $clog2(DIM),
    localparam int CADDR_W     = $clog2(DIM * DIM),
    localparam int RES_WIDTH   = A_DATA_WIDTH + B_DATA_WIDTH + $clog2(DIM)
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    output logic                 Busy,
    output logic                 Done,
    output logic                 RdEn,
    output logic [IDX_W-1:0]     ARowAddr,
    output logic [IDX_W-1:0]     BColAddr,
    input  logic [RES_WIDTH-1:0] DotProduct,
    output logic                 CWrEn,
    output logic [CADDR_W-1:0]   CAddr,
    output logic [RES_WIDTH-1:0] CData
);

    // One stage covers the operand memory read, the rest the datapath latency.
    localparam int DEPTH = 1 + DP_LATENCY;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   row;
    logic [IDX_W-1:0]   col;
    logic               last_issue;
    logic               drain_pending;
    logic [CADDR_W-1:0] issue_addr;
    logic [DEPTH-1:0]   pipe_valid;
    logic [CADDR_W-1:0] pipe_addr [DEPTH];

    assign last_issue = (row == LAST_IDX) && (col == LAST_IDX);
    assign issue_addr = CADDR_W'(row) * CADDR_W'(DIM) + CADDR_W'(col);

    // State register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Row/column walk: column is the fast index, both return to zero outside ISSUE.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            row <= '0;
            col <= '0;
        end else if (state == ISSUE) begin
            if (col == LAST_IDX) begin
                col <= '0;
                row <= (row == LAST_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else begin
            row <= '0;
            col <= '0;
        end
    end

    // Tracking pipeline: each issued pair carries its C address to the write stage.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pipe_valid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                pipe_addr[k] <= '0;
            end
        end else begin
            pipe_valid[0] <= RdEn;
            pipe_addr[0]  <= issue_addr;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_addr[k]  <= pipe_addr[k-1];
            end
        end
    end

    // Anything still in flight ahead of the tail; the tail itself writes this cycle.
    always_comb begin
        drain_pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            drain_pending = drain_pending | pipe_valid[k];
        end
    end

    // Next-state logic and per-state strobes.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        RdEn       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                Busy = 1'b1;
                RdEn = 1'b1;
                if (last_issue) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                Busy = 1'b1;
                if (!drain_pending) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ARowAddr = row;
    assign BColAddr = col;
    assign CWrEn    = pipe_valid[DEPTH-1];
    assign CAddr    = pipe_addr[DEPTH-1];
    assign CData    = DotProduct;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: drives two sequencers (DIM=2/latency 0 and
// DIM=4/latency 2) with operand memories and a dotProduct stand-in, and
// compares observed writes, issues, Busy and Done against matrix-level
// expectations derived from the start cycle.
module tb_dot_product_sequencer;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Clock generation.
    always #5 clk = ~clk;

    // Free-running cycle counter used to timestamp observations.
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         addr;
        logic [79:0] data;
    } wrRec_t;

    typedef struct {
        int cyc;
        int row;
        int col;
    } rdRec_t;

    // ---------------- DUT A: DIM=2, DP_LATENCY=0 ----------------
    logic        resetA, startA, busyA, doneA, rdEnA, cWrEnA;
    logic [0:0]  aRowA, bColA;
    logic [1:0]  cAddrA;
    logic [64:0] dotA, cDataA;
    logic [31:0] memA2 [2][2];
    logic [31:0] memB2 [2][2];
    logic [31:0] opA2 [2];
    logic [31:0] opB2 [2];

    dot_product_sequencer #(.DIM(2), .A_DATA_WIDTH(32), .B_DATA_WIDTH(32), .DP_LATENCY(0)) dutA (
        .Clock(clk), .Reset(resetA), .Start(startA), .Busy(busyA), .Done(doneA),
        .RdEn(rdEnA), .ARowAddr(aRowA), .BColAddr(bColA), .DotProduct(dotA),
        .CWrEn(cWrEnA), .CAddr(cAddrA), .CData(cDataA)
    );

    // Operand memories for A with one cycle of read latency.
    always @(posedge clk) begin
        if (rdEnA) begin
            for (int k = 0; k < 2; k++) begin
                opA2[k] <= memA2[aRowA][k];
                opB2[k] <= memB2[k][bColA];
            end
        end
    end

    // Combinational dotProduct stand-in for A.
    always_comb begin
        dotA = '0;
        for (int k = 0; k < 2; k++) begin
            dotA = dotA + 65'(opA2[k]) * 65'(opB2[k]);
        end
    end

    // ---------------- DUT B: DIM=4, DP_LATENCY=2 ----------------
    logic        resetB, startB, busyB, doneB, rdEnB, cWrEnB;
    logic [1:0]  aRowB, bColB;
    logic [3:0]  cAddrB;
    logic [65:0] dotB, dotBComb, dotBD1, cDataB;
    logic [31:0] memA [4][4];
    logic [31:0] memB [4][4];
    logic [31:0] opA [4];
    logic [31:0] opB [4];

    dot_product_sequencer #(.DIM(4), .A_DATA_WIDTH(32), .B_DATA_WIDTH(32), .DP_LATENCY(2)) dutB (
        .Clock(clk), .Reset(resetB), .Start(startB), .Busy(busyB), .Done(doneB),
        .RdEn(rdEnB), .ARowAddr(aRowB), .BColAddr(bColB), .DotProduct(dotB),
        .CWrEn(cWrEnB), .CAddr(cAddrB), .CData(cDataB)
    );

    // Operand memories for B with one cycle of read latency.
    always @(posedge clk) begin
        if (rdEnB) begin
            for (int k = 0; k < 4; k++) begin
                opA[k] <= memA[aRowB][k];
                opB[k] <= memB[k][bColB];
            end
        end
    end

    // dotProduct stand-in for B: sum of products, then two register stages.
    always_comb begin
        dotBComb = '0;
        for (int k = 0; k < 4; k++) begin
            dotBComb = dotBComb + 66'(opA[k]) * 66'(opB[k]);
        end
    end

    always @(posedge clk) begin
        dotBD1 <= dotBComb;
        dotB   <= dotBD1;
    end

    // ---------------- Monitors (sample on the falling edge) ----------------
    wrRec_t wrA[$];
    wrRec_t wrB[$];
    rdRec_t rdB[$];
    int     doneAQ[$];
    int     doneBQ[$];
    int     busyBQ[$];

    always @(negedge clk) begin
        wrRec_t w;
        rdRec_t r;
        if (cWrEnA) begin
            w.cyc = cyc; w.addr = int'(cAddrA); w.data = 80'(cDataA);
            wrA.push_back(w);
        end
        if (doneA) doneAQ.push_back(cyc);
        if (cWrEnB) begin
            w.cyc = cyc; w.addr = int'(cAddrB); w.data = 80'(cDataB);
            wrB.push_back(w);
        end
        if (rdEnB) begin
            r.cyc = cyc; r.row = int'(aRowB); r.col = int'(bColB);
            rdB.push_back(r);
        end
        if (doneB) doneBQ.push_back(cyc);
        if (busyB) busyBQ.push_back(cyc);
    end

    // ---------------- Reference model and helpers ----------------
    function automatic logic [65:0] refC(input int i, input int j);
        logic [65:0] s = '0;
        for (int m = 0; m < 4; m++) begin
            s = s + 66'(memA[i][m]) * 66'(memB[m][j]);
        end
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic fillMatrices(input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (mode)
                    0: begin memA[i][j] = (i == j) ? 32'd1 : 32'd0; memB[i][j] = (i == j) ? 32'd1 : 32'd0; end
                    1: begin memA[i][j] = 32'hFFFF_FFFF; memB[i][j] = 32'hFFFF_FFFF; end
                    default: begin memA[i][j] = $urandom; memB[i][j] = $urandom; end
                endcase
            end
        end
    endtask

    // Pulse Start on B and let the run (and an optional back-to-back run) complete.
    task automatic applyStimulus(input bit pulseExtra, input bit backToBack, output int kStart);
        @(posedge clk); #1;
        kStart = cyc;
        startB = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            startB = (pulseExtra && (cyc == kStart + 5 || cyc == kStart + 20)) ||
                     (backToBack && cyc == kStart + 21);
        end
        startB = 1'b0;
    endtask

    // Compare one 16-pair run on B that started at edge k against the model.
    task automatic checkRunB(input int k, input int wb, input int db, input int rb, input int bb);
        for (int n = 0; n < 16; n++) begin
            if (wb + n < wrB.size()) begin
                checkOutput($sformatf("wrB[%0d].cycle", n), 80'(wrB[wb+n].cyc), 80'(k + 4 + n));
                checkOutput($sformatf("wrB[%0d].addr", n), 80'(wrB[wb+n].addr), 80'(n));
                checkOutput($sformatf("wrB[%0d].data", n), wrB[wb+n].data, 80'(refC(n / 4, n % 4)));
            end
            if (rb + n < rdB.size()) begin
                checkOutput($sformatf("rdB[%0d].cycle", n), 80'(rdB[rb+n].cyc), 80'(k + 1 + n));
                checkOutput($sformatf("rdB[%0d].pair", n), 80'(rdB[rb+n].row * 4 + rdB[rb+n].col), 80'(n));
            end
        end
        if (db < doneBQ.size()) checkOutput("doneB.cycle", 80'(doneBQ[db]), 80'(k + 20));
        if (bb < busyBQ.size()) checkOutput("busyB.first", 80'(busyBQ[bb]), 80'(k + 1));
        if (bb + 18 < busyBQ.size()) checkOutput("busyB.last", 80'(busyBQ[bb+18]), 80'(k + 19));
    endtask

    // ---------------- Directed sequence ----------------
    initial begin
        int k;
        int wb, db, rb, bb;
        int kA;
        int expA [4];
        expA = '{19, 22, 43, 50};

        resetA = 1'b1; resetB = 1'b1; startA = 1'b0; startB = 1'b0;
        memA2[0][0] = 32'd1; memA2[0][1] = 32'd2; memA2[1][0] = 32'd3; memA2[1][1] = 32'd4;
        memB2[0][0] = 32'd5; memB2[0][1] = 32'd6; memB2[1][0] = 32'd7; memB2[1][1] = 32'd8;
        fillMatrices(0);

        $display("[TB] reset values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset.busyB", 80'(busyB), 80'(0));
        checkOutput("reset.doneB", 80'(doneB), 80'(0));
        checkOutput("reset.rdEnB", 80'(rdEnB), 80'(0));
        checkOutput("reset.cWrEnB", 80'(cWrEnB), 80'(0));
        checkOutput("reset.aRowB", 80'(aRowB), 80'(0));
        checkOutput("reset.bColB", 80'(bColB), 80'(0));
        checkOutput("reset.cAddrB", 80'(cAddrB), 80'(0));
        checkOutput("reset.busyA", 80'(busyA), 80'(0));
        checkOutput("reset.cWrEnA", 80'(cWrEnA), 80'(0));
        @(posedge clk); #1;
        resetA = 1'b0; resetB = 1'b0;

        $display("[TB] DIM=2 worked example");
        while (cyc < 10) begin
            @(posedge clk); #1;
        end
        kA = cyc;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput("wrA.count", 80'(wrA.size()), 80'(4));
        for (int n = 0; n < 4 && n < wrA.size(); n++) begin
            checkOutput($sformatf("wrA[%0d].cycle", n), 80'(wrA[n].cyc), 80'(kA + 2 + n));
            checkOutput($sformatf("wrA[%0d].addr", n), 80'(wrA[n].addr), 80'(n));
            checkOutput($sformatf("wrA[%0d].data", n), wrA[n].data, 80'(expA[n]));
        end
        checkOutput("doneA.count", 80'(doneAQ.size()), 80'(1));
        if (doneAQ.size() > 0) checkOutput("doneA.cycle", 80'(doneAQ[0]), 80'(kA + 6));

        $display("[TB] identity matrices");
        fillMatrices(0);
        wb = wrB.size(); db = doneBQ.size(); rb = rdB.size(); bb = busyBQ.size();
        applyStimulus(1'b0, 1'b0, k);
        checkRunB(k, wb, db, rb, bb);
        checkOutput("ident.wrCount", 80'(wrB.size() - wb), 80'(16));
        checkOutput("ident.doneCount", 80'(doneBQ.size() - db), 80'(1));
        checkOutput("ident.busyCount", 80'(busyBQ.size() - bb), 80'(19));

        $display("[TB] all-ones maximum operands");
        fillMatrices(1);
        wb = wrB.size(); db = doneBQ.size(); rb = rdB.size(); bb = busyBQ.size();
        applyStimulus(1'b0, 1'b0, k);
        checkRunB(k, wb, db, rb, bb);
        checkOutput("max.wrCount", 80'(wrB.size() - wb), 80'(16));
        if (wb + 15 < wrB.size()) checkOutput("max.value", wrB[wb+15].data, 80'h3_FFFF_FFF8_0000_0004);

        $display("[TB] random operands, Start pulsed while busy and during Done");
        fillMatrices(2);
        wb = wrB.size(); db = doneBQ.size(); rb = rdB.size(); bb = busyBQ.size();
        applyStimulus(1'b1, 1'b0, k);
        checkRunB(k, wb, db, rb, bb);
        checkOutput("pulse.wrCount", 80'(wrB.size() - wb), 80'(16));
        checkOutput("pulse.doneCount", 80'(doneBQ.size() - db), 80'(1));
        checkOutput("pulse.issueCount", 80'(rdB.size() - rb), 80'(16));

        $display("[TB] reset midway through issue");
        fillMatrices(2);
        wb = wrB.size(); db = doneBQ.size(); rb = rdB.size();
        @(posedge clk); #1;
        k = cyc;
        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        for (int c = 0; c < 20 && cyc < k + 8; c++) begin
            @(posedge clk); #1;
        end
        resetB = 1'b1;
        @(posedge clk); #1;
        resetB = 1'b0;
        @(negedge clk);
        checkOutput("rst.rdEnB", 80'(rdEnB), 80'(0));
        checkOutput("rst.cWrEnB", 80'(cWrEnB), 80'(0));
        checkOutput("rst.busyB", 80'(busyB), 80'(0));
        repeat (30) @(posedge clk);
        @(negedge clk);
        checkOutput("rst.wrCount", 80'(wrB.size() - wb), 80'(5));
        checkOutput("rst.issueCount", 80'(rdB.size() - rb), 80'(8));
        checkOutput("rst.doneCount", 80'(doneBQ.size() - db), 80'(0));
        for (int n = 0; n < 5 && wb + n < wrB.size(); n++) begin
            checkOutput($sformatf("rst.wr[%0d].addr", n), 80'(wrB[wb+n].addr), 80'(n));
        end

        $display("[TB] full run after reset");
        fillMatrices(2);
        wb = wrB.size(); db = doneBQ.size(); rb = rdB.size(); bb = busyBQ.size();
        applyStimulus(1'b0, 1'b0, k);
        checkRunB(k, wb, db, rb, bb);
        checkOutput("post.wrCount", 80'(wrB.size() - wb), 80'(16));
        checkOutput("post.doneCount", 80'(doneBQ.size() - db), 80'(1));

        $display("[TB] back-to-back runs");
        fillMatrices(2);
        wb = wrB.size(); db = doneBQ.size(); rb = rdB.size(); bb = busyBQ.size();
        applyStimulus(1'b0, 1'b1, k);
        checkRunB(k, wb, db, rb, bb);
        checkRunB(k + 21, wb + 16, db + 1, rb + 16, bb + 19);
        checkOutput("b2b.wrCount", 80'(wrB.size() - wb), 80'(32));
        checkOutput("b2b.doneCount", 80'(doneBQ.size() - db), 80'(2));
        checkOutput("b2b.busyCount", 80'(busyBQ.size() - bb), 80'(38));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
